// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. The functions work on MAX_W-bit values, so any
// narrower width is zero-extended by the caller and truncated on return.
package gray_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it. Zero padding
  // above a narrower width leaves the result unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode_n.sv
// Combinational binary-to-Gray encoder of arbitrary width (up to MAX_W).
module gray_encode_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_counter_sync.sv
// Registered up/down Gray counter with load, wrap/saturate and a tc pulse.
// gray and bin are both taken from the same edge, straight from flops.
module gray_counter_sync
  import gray_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter bit          WRAP    = 1'b1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_W'(RST_BIN)));
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_BIN  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             tc_nxt;

  // tc flags the end-of-range step: the wrap itself, or a blocked saturating step.
  always_comb begin
    bin_nxt = bin;
    tc_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin == MAX_BIN) begin
          tc_nxt = 1'b1;
          if (WRAP) bin_nxt = '0;
        end else begin
          bin_nxt = bin + ONE;
        end
      end else begin
        if (bin == '0) begin
          tc_nxt = 1'b1;
          if (WRAP) bin_nxt = MAX_BIN;
        end else begin
          bin_nxt = bin - ONE;
        end
      end
    end
  end

  gray_encode_n #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= RST_BIN;
      gray <= RST_GRAY;
      tc   <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      tc   <= tc_nxt;
    end
  end

endmodule
